// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the paged buffer RAM
package mem_pkg;

    // Read-path flavours of the paged RAM
    localparam string PERF_HIGH = "HIGH_PERFORMANCE";
    localparam string PERF_LOW  = "LOW_LATENCY";

    // Number of bits needed to index 'value' distinct items; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Port widths never collapse to zero bits
    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/paged_bram_outreg.sv
// rtl/paged_bram_outreg.sv - optional BRAM output register with clock enable
module paged_bram_outreg
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r = '0;

    // Second pipeline stage: capture the read latch when enabled, clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else if (ce) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/paged_bram.sv
// rtl/paged_bram.sv - paged simple-dual-port RAM with per-page entry counts
module paged_bram
    import mem_pkg::*;
#(
    parameter int    RAM_WIDTH       = 32,
    parameter int    RAM_DEPTH       = 16,
    parameter int    PAGES           = 2,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int    HEX             = 1,
    parameter string INIT_FILE       = "",
    localparam int   AW              = at_least_one(clog2(RAM_DEPTH)),
    localparam int   PW              = at_least_one(clog2(PAGES)),
    localparam int   NW              = clog2(RAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wea,
    input  logic [PW-1:0]        pagea,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [NW-1:0]        nent_i,
    input  logic                 enb,
    input  logic [PW-1:0]        pageb,
    input  logic [AW-1:0]        addrb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic [NW-1:0]        nent_o
);

    localparam int TOTAL = PAGES * RAM_DEPTH;
    localparam int MW    = at_least_one(clog2(TOTAL));

    typedef logic [RAM_WIDTH-1:0] mem_t [TOTAL];

    // Power-up contents: zeros
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < TOTAL; i++) begin
            m[i] = '0;
        end
        return m;
    endfunction

    mem_t                 mem = init_mem();
    logic [RAM_WIDTH-1:0] rd_q = '0;
    logic [NW-1:0]        nent [PAGES] = '{default: '0};

    logic [PW-1:0] page_a;
    logic [PW-1:0] page_b;
    logic [MW-1:0] phys_a;
    logic [MW-1:0] phys_b;
    logic          a_in_range;
    logic          b_in_range;

    // Out-of-range page numbers fold back onto the existing pages
    assign page_a = PW'(32'(pagea) % PAGES);
    assign page_b = PW'(32'(pageb) % PAGES);

    // Each page occupies a contiguous RAM_DEPTH-word window
    assign phys_a = MW'(32'(page_a) * RAM_DEPTH + 32'(addra));
    assign phys_b = MW'(32'(page_b) * RAM_DEPTH + 32'(addrb));

    // Word addresses past the page end never touch storage
    assign a_in_range = 32'(addra) < RAM_DEPTH;
    assign b_in_range = 32'(addrb) < RAM_DEPTH;

    // Port A write; kept reset-free so the array maps onto block RAM, but a
    // write that coincides with reset is discarded
    always_ff @(posedge clk) begin
        if (!reset && wea && a_in_range) begin
            mem[phys_a] <= dina;
        end
    end

    // Port B read latch; read-first because the write above lands in the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (enb) begin
            rd_q <= b_in_range ? mem[phys_b] : '0;
        end
    end

    // Entry count per page, updated together with every port A write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PAGES; i++) begin
                nent[i] <= '0;
            end
        end else if (wea) begin
            nent[page_a] <= nent_i;
        end
    end

    assign nent_o = nent[page_b];

    generate
        if (RAM_PERFORMANCE == PERF_LOW) begin : g_low_latency
            // The output register is bypassed, so regceb has no effect here
            logic unused_regceb;
            assign unused_regceb = regceb;
            assign doutb         = rd_q;
        end else begin : g_high_performance
            paged_bram_outreg #(
                .WIDTH (RAM_WIDTH)
            ) u_outreg (
                .clk   (clk),
                .reset (reset),
                .ce    (regceb),
                .d     (rd_q),
                .q     (doutb)
            );
        end
    endgenerate

endmodule

// File: tb/tb_paged_bram.sv
// tb/tb_paged_bram.sv - scoreboard bench for paged_bram in both read flavours
module tb_paged_bram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Low-latency instance, two pages
    logic        ll_rst, ll_wea, ll_enb, ll_regceb, ll_chk;
    logic [0:0]  ll_pagea, ll_pageb;
    logic [3:0]  ll_addra, ll_addrb;
    logic [31:0] ll_dina, ll_doutb;
    logic [4:0]  ll_nent_i, ll_nent_o;

    // High-performance instance, four pages
    logic        hp_rst, hp_wea, hp_enb, hp_regceb, hp_chk;
    logic [1:0]  hp_pagea, hp_pageb;
    logic [3:0]  hp_addra, hp_addrb;
    logic [31:0] hp_dina, hp_doutb;
    logic [4:0]  hp_nent_i, hp_nent_o;

    paged_bram #(
        .RAM_WIDTH(32), .RAM_DEPTH(16), .PAGES(2), .RAM_PERFORMANCE("LOW_LATENCY")
    ) u_ll (
        .clk(clk), .reset(ll_rst), .wea(ll_wea), .pagea(ll_pagea), .addra(ll_addra),
        .dina(ll_dina), .nent_i(ll_nent_i), .enb(ll_enb), .pageb(ll_pageb),
        .addrb(ll_addrb), .regceb(ll_regceb), .doutb(ll_doutb), .nent_o(ll_nent_o)
    );

    paged_bram #(
        .RAM_WIDTH(32), .RAM_DEPTH(16), .PAGES(4), .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_hp (
        .clk(clk), .reset(hp_rst), .wea(hp_wea), .pagea(hp_pagea), .addra(hp_addra),
        .dina(hp_dina), .nent_i(hp_nent_i), .enb(hp_enb), .pageb(hp_pageb),
        .addrb(hp_addrb), .regceb(hp_regceb), .doutb(hp_doutb), .nent_o(hp_nent_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ll_q[$];
    logic [31:0] hp_q[$];

    logic ll_vld = 1'b0;
    logic hp_v1  = 1'b0;
    logic hp_v2  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-data latency tracking for checked reads only
    always @(posedge clk) begin
        ll_vld <= ll_enb && ll_chk && !ll_rst;
        hp_v1  <= hp_enb && hp_chk && !hp_rst;
        hp_v2  <= hp_v1 && hp_regceb && !hp_rst;
    end

    // Monitor: whenever a checked read reaches doutb, pop and compare
    always @(negedge clk) begin
        if (ll_vld) begin
            if (ll_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ll_read: data 0x%08h with empty scoreboard", ll_doutb);
            end else begin
                check("ll_read", ll_doutb, ll_q.pop_front());
            end
        end
        if (hp_v2) begin
            if (hp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL hp_read: data 0x%08h with empty scoreboard", hp_doutb);
            end else begin
                check("hp_read", hp_doutb, hp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        ll_wea = 1'b0; ll_enb = 1'b0; ll_chk = 1'b0;
        hp_wea = 1'b0; hp_enb = 1'b0; hp_chk = 1'b0;
    endtask

    task automatic ll_wr(input int p, input int a, input logic [31:0] d, input int n);
        ll_wea = 1'b1; ll_pagea = 1'(p); ll_addra = 4'(a); ll_dina = d; ll_nent_i = 5'(n);
    endtask

    task automatic ll_rd(input int p, input int a, input logic [31:0] e, input bit chk);
        ll_enb = 1'b1; ll_pageb = 1'(p); ll_addrb = 4'(a); ll_chk = chk;
        if (chk) ll_q.push_back(e);
    endtask

    task automatic hp_wr(input int p, input int a, input logic [31:0] d, input int n);
        hp_wea = 1'b1; hp_pagea = 2'(p); hp_addra = 4'(a); hp_dina = d; hp_nent_i = 5'(n);
    endtask

    task automatic hp_rd(input int p, input int a, input logic [31:0] e, input bit chk);
        hp_enb = 1'b1; hp_pageb = 2'(p); hp_addrb = 4'(a); hp_chk = chk;
        if (chk) hp_q.push_back(e);
    endtask

    function automatic logic [31:0] pp(input int r, input int i);
        return 32'h5A00_0000 | 32'(r << 8) | 32'(i);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ll_rst = 1'b1; ll_wea = 1'b0; ll_enb = 1'b0; ll_regceb = 1'b0; ll_chk = 1'b0;
        ll_pagea = '0; ll_pageb = '0; ll_addra = '0; ll_addrb = '0; ll_dina = '0; ll_nent_i = '0;
        hp_rst = 1'b1; hp_wea = 1'b0; hp_enb = 1'b0; hp_regceb = 1'b1; hp_chk = 1'b0;
        hp_pagea = '0; hp_pageb = '0; hp_addra = '0; hp_addrb = '0; hp_dina = '0; hp_nent_i = '0;
        repeat (3) cyc();
        ll_rst = 1'b0;
        hp_rst = 1'b0;

        check("ll_reset_dout", ll_doutb, 32'h0);
        check("ll_reset_nent", 32'(ll_nent_o), 32'h0);
        check("hp_reset_dout", hp_doutb, 32'h0);
        check("hp_reset_nent", 32'(hp_nent_o), 32'h0);

        // One-cycle read latency
        ll_wr(0, 3, 32'hDEAD_BEEF, 0); cyc();
        ll_rd(0, 3, 32'hDEAD_BEEF, 1); cyc();

        // Page isolation and page-number wrap (page 2 lands on page 0)
        ll_wr(0, 5, 32'h11, 0); cyc();
        ll_wr(1, 5, 32'h22, 0); cyc();
        ll_rd(0, 5, 32'h11, 1); cyc();
        ll_rd(1, 5, 32'h22, 1); cyc();
        ll_wr(2, 5, 32'h33, 0); cyc();
        ll_rd(0, 5, 32'h33, 1); cyc();
        ll_rd(1, 5, 32'h22, 1); cyc();

        // Entry counts, then reset clearing data and counts and dropping a write
        ll_wr(1, 0, 32'h00C0_FFEE, 7); cyc();
        ll_pageb = 1'b1; #1;
        check("ll_nent_p1", 32'(ll_nent_o), 32'd7);
        ll_pageb = 1'b0; #1;
        check("ll_nent_p0", 32'(ll_nent_o), 32'd0);
        ll_rd(1, 5, 32'h22, 1); cyc();
        ll_rst = 1'b1;
        ll_wr(1, 6, 32'h99, 5); cyc();
        ll_rst = 1'b0; ll_pageb = 1'b1; #1;
        check("ll_rst_dout", ll_doutb, 32'h0);
        check("ll_rst_nent", 32'(ll_nent_o), 32'd0);
        ll_rd(1, 6, 32'h0, 1); cyc();
        check("ll_drop_nent", 32'(ll_nent_o), 32'd0);

        // Same-address read and write in one cycle is read-first
        ll_wr(0, 2, 32'hA, 0); cyc();
        ll_wr(0, 2, 32'hB, 0); ll_rd(0, 2, 32'hA, 1); cyc();
        ll_rd(0, 2, 32'hB, 1); cyc();

        // Two-cycle read latency, then output hold with regceb low
        hp_wr(0, 3, 32'hDEAD_BEEF, 0); cyc();
        hp_wr(0, 4, 32'h0000_1234, 0); cyc();
        hp_rd(0, 3, 32'hDEAD_BEEF, 1); cyc();
        cyc();
        hp_regceb = 1'b0;
        hp_rd(0, 4, 32'h0, 0); cyc();
        check("hp_hold", hp_doutb, 32'hDEAD_BEEF);
        hp_regceb = 1'b1; cyc();
        check("hp_release", hp_doutb, 32'h0000_1234);

        // Reset while a read is in flight discards it
        hp_rd(0, 3, 32'h0, 0); cyc();
        hp_rst = 1'b1; cyc();
        hp_rst = 1'b0;
        check("hp_midrst_0", hp_doutb, 32'h0);
        cyc();
        check("hp_midrst_1", hp_doutb, 32'h0);
        check("hp_midrst_nent", 32'(hp_nent_o), 32'h0);

        // Ping-pong: write page r while streaming page r-1
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++) begin
                hp_wr(r % 4, i, pp(r, i), 16 - r);
                if (r > 0) hp_rd((r - 1) % 4, i, pp(r - 1, i), 1);
                cyc();
                if (r > 0 && i == 0) check("hp_pp_nent", 32'(hp_nent_o), 32'(17 - r));
            end
        end

        for (int k = 0; k < 10 && (ll_q.size() != 0 || hp_q.size() != 0); k++) cyc();
        cyc();
        n_vec++;
        if (ll_q.size() + hp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d reads never reached doutb, expected 0",
                     ll_q.size() + hp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
